ram_mem: RTL
============

RAM_MEM -- requirements
Module: ram_mem

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning: access latency in clock cycles from request acceptance to MOC; legal range 1..15.
REQ-002 Parameter DEPTH, default 256, meaning: storage size in bytes; byte address width is 8.
REQ-003 Port CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Port CLR  input  1  reset; asynchronous, active-high.
REQ-005 Port MOV  input  1  memory operation valid; the control unit's request, held high until MOC is seen.
REQ-006 Port RW  input  1  direction; 1 = read, 0 = write.
REQ-007 Port typeData  input  2  access size; 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 Port address  input  8  byte address, driven by the MAR.
REQ-009 Port dataIn  input  32  write data, driven by the MDR; right-justified for byte and halfword.
REQ-010 Port dataOut  output  32  read data, registered, zero-extended; feeds the MDR.
REQ-011 Port MOC  output  1  memory operation complete, registered.

Function
REQ-012 The controller SHALL be a three-state FSM: IDLE, ACCESS, DONE.
REQ-013 In IDLE with MOV=1 at a rising edge, the block SHALL latch RW, typeData, address and dataIn, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-014 Inputs changing after acceptance SHALL have no effect until the FSM returns to IDLE.
REQ-015 In ACCESS, the counter SHALL decrement once per edge; at the edge where it reads 0, the access SHALL be performed, the FSM SHALL enter DONE, and MOC SHALL be set to 1.
REQ-016 MOC SHALL therefore first read 1 exactly WAIT_CYCLES edges after the accepting edge.
REQ-017 In DONE, MOC SHALL stay 1 while MOV=1; at the first edge with MOV=0, the FSM SHALL return to IDLE and MOC SHALL clear.
REQ-018 A new request SHALL NOT be accepted in the DONE-to-IDLE edge; the minimum spacing between requests is one IDLE cycle.
REQ-019 Storage SHALL be big-endian: the lowest address holds the most significant byte.
REQ-020 Halfword accesses SHALL force address[0]=0, and word accesses SHALL force address[1:0]=00; no access wraps past DEPTH-1.
REQ-021 A byte write SHALL store dataIn[7:0], a halfword write dataIn[15:0], and a word write dataIn[31:0]; unaddressed bytes are unchanged.
REQ-022 A read SHALL load dataOut with the addressed data right-justified and upper bits zero, and dataOut SHALL hold that value until the next completed read.
REQ-023 A write SHALL leave dataOut unchanged.
REQ-024 MOV deasserting while in ACCESS SHALL NOT abort the access; completion and MOC still occur, and DONE exits on the next edge.

Reset
REQ-025 While CLR=1, the state SHALL be IDLE, MOC 0, dataOut 32'h0, and the counter 0, independent of CLK.
REQ-026 CLR asserted mid-access SHALL abort the access, and a pending write SHALL NOT modify storage.
REQ-027 Storage contents SHALL NOT be cleared by CLR.
REQ-028 The first request SHALL be accepted on the first rising edge with CLR=0 and MOV=1.

Structure
REQ-029 A shared package SHALL hold the typeData encodings (BYTE, HALF, WORD), the FSM state encodings, and the DEPTH default.
REQ-030 The byte array with its big-endian lane steering SHALL be one sub-module, ram_array, and the FSM, counter and output registers SHALL stay in ram_mem.

Verification
REQ-031 Word write then read: write 32'hE2010000 to address 8'h04, then read a word from 8'h04. Required response: MOC high 2 edges after each acceptance, and dataOut = 32'hE2010000.
REQ-032 Byte lanes: after REQ-031, read a byte at 8'h04, then a byte at 8'h07. Required response: dataOut = 32'h000000E2, then 32'h00000000.
REQ-033 Misaligned access: write halfword 16'hBEEF at 8'h11, then read a word at 8'h10. Required response: dataOut[31:16] = 16'hBEEF, and bytes 8'h12..8'h13 are unchanged.
REQ-034 Handshake hold: hold MOV=1 for 5 cycles after MOC rises. Required response: MOC stays 1 throughout, clears one edge after MOV falls, and no second access occurs.
REQ-035 Reset abort: assert CLR between the accepting edge and MOC for a word write of 32'hFFFFFFFF to 8'h20. Required response: MOC never rises, and a later read of 8'h20 returns the prior contents.
REQ-036 Latency sweep: run WAIT_CYCLES = 1 and 15 with back-to-back reads. Required response: MOC latency equals WAIT_CYCLES, with one IDLE cycle between requests.

Source files
------------

// File: rtl/ram_mem_pkg.sv
// Shared definitions for the ram_mem block: access-size and controller-state
// encodings, the default storage depth, and address helpers.
package ram_mem_pkg;

  localparam int DEFAULT_DEPTH = 256;
  localparam int ADDR_W        = 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  // typeData 2'b11 has no size of its own and behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] t);
    case (t)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                   input size_t s);
    case (s)
      HALF:    return {a[ADDR_W-1:1], 1'b0};
      WORD:    return {a[ADDR_W-1:2], 2'b00};
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/ram_array.sv
// Byte-addressed storage split into four byte lanes; lane 0 holds the most
// significant byte of each word, so the lowest address maps to the MSB.
module ram_array
  import ram_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  size_t             size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int WORDS = DEPTH / 4;
  localparam int IDX_W = $clog2(WORDS);

  logic [IDX_W-1:0] widx;
  logic [7:0]       lane_rd [4];

  assign widx = addr[IDX_W+1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);

    logic [7:0] bank [WORDS];
    logic       lane_we;
    logic [7:0] lane_wd;

    // Right-justified write data is steered onto the lanes it addresses.
    always_comb begin
      lane_we = 1'b0;
      lane_wd = wdata[7:0];
      case (size)
        WORD: begin
          lane_we = we;
          lane_wd = wdata[31-8*gi -: 8];
        end
        HALF: begin
          lane_we = we && (addr[1] == LANE[1]);
          lane_wd = LANE[0] ? wdata[7:0] : wdata[15:8];
        end
        default: begin
          lane_we = we && (addr[1:0] == LANE);
          lane_wd = wdata[7:0];
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (lane_we) begin
        bank[widx] <= lane_wd;
      end
    end

    assign lane_rd[gi] = bank[widx];
  end

  always_comb begin
    rdata = '0;
    case (size)
      WORD:    rdata = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
      HALF:    rdata = addr[1] ? {16'h0, lane_rd[2], lane_rd[3]}
                               : {16'h0, lane_rd[0], lane_rd[1]};
      default: rdata = {24'h0, lane_rd[addr[1:0]]};
    endcase
  end

endmodule

// File: rtl/ram_mem.sv
// Memory with a MOV/MOC handshake: a request is latched, completes after
// WAIT_CYCLES edges, and MOC is held until the requester drops MOV.
module ram_mem
  import ram_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = DEFAULT_DEPTH
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [7:0]  address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        MOC
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        rw_reg;
  size_t       size_reg;
  logic [7:0]  addr_reg;
  logic [31:0] din_reg;
  logic [31:0] rd_data;
  logic        fire;
  logic        mem_we;

  // The access happens on the edge where the counter is seen at zero.
  assign fire   = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign mem_we = fire && !rw_reg;

  ram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .size (size_reg),
    .addr (addr_reg),
    .wdata(din_reg),
    .rdata(rd_data)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      MOC       <= 1'b0;
      dataOut   <= 32'h0;
      rw_reg    <= 1'b1;
      size_reg  <= BYTE;
      addr_reg  <= 8'h0;
      din_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          MOC <= 1'b0;
          if (MOV) begin
            rw_reg    <= RW;
            size_reg  <= decode_size(typeData);
            addr_reg  <= align_addr(address, decode_size(typeData));
            din_reg   <= dataIn;
            cnt_reg   <= CNT_LOAD;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
            MOC       <= 1'b1;
            if (rw_reg) begin
              dataOut <= rd_data;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          if (!MOV) begin
            state_reg <= IDLE;
            MOC       <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          MOC       <= 1'b0;
        end
      endcase
    end
  end

endmodule
